cacheline_burst_adaptor: RTL and testbench
==========================================

CACHELINE_BURST_ADAPTOR -- requirements
Module: cacheline_burst_adaptor

Interface
REQ-001 Parameter LINE_WIDTH, default 256: cache line width in bits.
REQ-002 Parameter BURST_WIDTH, default 64: memory beat width in bits; LINE_WIDTH SHALL be a power-of-two multiple of BURST_WIDTH, BEATS = LINE_WIDTH/BURST_WIDTH >= 2.
REQ-003 Parameter ADDR_WIDTH, default 32: address width in bits.
REQ-004 Parameter LINE_BYTES, derived = LINE_WIDTH/8: bytes per line, used for address alignment.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 line_i  input  LINE_WIDTH  write data from LLC.
REQ-008 line_o  output  LINE_WIDTH  read data to LLC.
REQ-009 address_i  input  ADDR_WIDTH  LLC request address.
REQ-010 read_i / write_i  input  1 each  LLC read / write request, level, held until resp_o.
REQ-011 resp_o  output  1  one-cycle completion pulse to LLC.
REQ-012 burst_i  input  BURST_WIDTH  read beat from memory.
REQ-013 burst_o  output  BURST_WIDTH  write beat to memory.
REQ-014 address_o  output  ADDR_WIDTH  line-aligned memory address.
REQ-015 read_o / write_o  output  1 each  memory read / write request.
REQ-016 resp_i  input  1  memory beat strobe; each high cycle = one beat transferred.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-018 IDLE: if write_i=1 -> WRITE (write wins when read_i and write_i are both high); else if read_i=1 -> READ; else stay.
REQ-019 On acceptance, address_i with low log2(LINE_BYTES) bits cleared SHALL be latched to address_o, line_i SHALL be latched to an internal buffer (write), beat counter SHALL clear to 0.
REQ-020 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE; first assertion is the cycle after acceptance.
REQ-021 READ: each cycle with resp_i=1 SHALL store burst_i into buffer slot [cnt*BURST_WIDTH +: BURST_WIDTH] and increment cnt; cycles with resp_i=0 (gaps) SHALL hold cnt and buffer.
REQ-022 WRITE: burst_o SHALL equal buffer slot cnt at all times in WRITE; cnt SHALL increment on each resp_i=1 cycle.
REQ-023 When resp_i=1 with cnt=BEATS-1, FSM SHALL go to DONE and cnt SHALL wrap to 0; read_o/write_o drop the same edge.
REQ-024 DONE: resp_o=1 for exactly one cycle, then unconditionally IDLE; request inputs are not sampled in DONE.
REQ-025 line_o SHALL be updated from the buffer only on entry to DONE from READ and SHALL hold its value otherwise (including across writes).
REQ-026 read_i, write_i, address_i, line_i changes outside IDLE SHALL be ignored.
REQ-027 resp_i=1 in IDLE or DONE SHALL be ignored (no counter or data change).
REQ-028 burst_o SHALL be 0 outside WRITE.

Reset
REQ-029 reset=1 SHALL immediately (asynchronously) force state IDLE, cnt=0, read_o=0, write_o=0, resp_o=0, burst_o=0, address_o=0, line_o=0, buffer=0.
REQ-030 Reset mid-transaction SHALL abort it with no resp_o; the first request after reset deassertion is accepted normally.

Verification
REQ-031 Read, defaults: read_i=1, address_i=0x0000_1234, resp_i high 4 consecutive cycles with beats 0xA0..,0xA1..,0xA2..,0xA3.. -> address_o=0x0000_1220, read_o high until last beat, resp_o one pulse, line_o={A3,A2,A1,A0}.
REQ-032 Write with gaps: write_i=1, line_i=256'h{D3,D2,D1,D0}, resp_i pattern 1,0,1,0,0,1,1 -> burst_o steps D0,D1,D2,D3 only on resp_i edges, resp_o once after 4th beat.
REQ-033 Simultaneous read_i=1 and write_i=1 in IDLE -> write_o=1, read_o=0, line_o unchanged from prior read.
REQ-034 Reset asserted after 2 read beats, asynchronous to clk -> outputs 0 immediately, no resp_o; next read completes with correct line.
REQ-035 Parameter set LINE_WIDTH=512, BURST_WIDTH=128 -> 4 beats, address low 6 bits cleared; LINE_WIDTH=128, BURST_WIDTH=32 -> 4 beats, low 4 bits cleared; spurious resp_i in IDLE -> no state change.

Source files
------------

// File: rtl/cacheline_burst_adaptor.sv
// Cache line <-> memory burst adaptor: splits an LLC line write into BEATS memory beats
// and gathers BEATS memory read beats into one line.
module cacheline_burst_adaptor #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_BYTES  = LINE_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFFS  = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                                 state;
    logic [CNT_W-1:0]                       cnt;
    logic [BEATS-1:0][BURST_WIDTH-1:0]      buffer;
    logic [CNT_W-1:0]                       cnt_inc;
    logic                                   last;
    logic [ADDR_WIDTH-1:0]                  aligned;

    assign cnt_inc = cnt + CNT_W'(1);
    assign last    = (cnt == CNT_W'(BEATS - 1));
    assign aligned = {address_i[ADDR_WIDTH-1:OFFS], OFFS'(0)};

    // Single registered FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            buffer    <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            burst_o   <= '0;
            address_o <= '0;
            line_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        state     <= WRITE;
                        write_o   <= 1'b1;
                        address_o <= aligned;
                        buffer    <= line_i;
                        cnt       <= '0;
                        burst_o   <= line_i[BURST_WIDTH-1:0];
                    end else if (read_i) begin
                        state     <= READ;
                        read_o    <= 1'b1;
                        address_o <= aligned;
                        cnt       <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        buffer[cnt] <= burst_i;
                        cnt         <= cnt_inc;
                        if (last) begin
                            state  <= DONE;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            // Last beat fills the top slot; publish the merged line now.
                            line_o <= {burst_i, buffer[BEATS-2:0]};
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt_inc;
                        if (last) begin
                            state   <= DONE;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            burst_o <= '0;
                        end else begin
                            burst_o <= buffer[cnt_inc];
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: default build plus 512/128 and 128/32 builds.
module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         reset;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [63:0]  burst_i, burst_o;

    // shared request signals for the alternate-parameter builds
    logic         p_read, p_resp;
    logic [31:0]  p_addr;
    logic [511:0] w_line_o;
    logic [127:0] w_burst_i, w_burst_o;
    logic [31:0]  w_addr_o;
    logic         w_resp_o, w_read_o, w_write_o;
    logic [127:0] n_line_o;
    logic [31:0]  n_burst_i, n_burst_o;
    logic [31:0]  n_addr_o;
    logic         n_resp_o, n_read_o, n_write_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0]  a_beat [4];
    logic [63:0]  c_beat [4];
    logic [63:0]  d_beat [4];
    logic [127:0] w_beat [4];
    logic [31:0]  n_beat [4];
    logic [255:0] a_line;

    cacheline_burst_adaptor dut (
        .clk(clk), .reset(reset), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    cacheline_burst_adaptor #(.LINE_WIDTH(512), .BURST_WIDTH(128)) dut_wide (
        .clk(clk), .reset(reset), .line_i(512'd0), .line_o(w_line_o),
        .address_i(p_addr), .read_i(p_read), .write_i(1'b0), .resp_o(w_resp_o),
        .burst_i(w_burst_i), .burst_o(w_burst_o), .address_o(w_addr_o),
        .read_o(w_read_o), .write_o(w_write_o), .resp_i(p_resp)
    );

    cacheline_burst_adaptor #(.LINE_WIDTH(128), .BURST_WIDTH(32)) dut_narrow (
        .clk(clk), .reset(reset), .line_i(128'd0), .line_o(n_line_o),
        .address_i(p_addr), .read_i(p_read), .write_i(1'b0), .resp_o(n_resp_o),
        .burst_i(n_burst_i), .burst_o(n_burst_o), .address_o(n_addr_o),
        .read_o(n_read_o), .write_o(n_write_o), .resp_i(p_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            a_beat[k] = {8{8'(8'hA0 + k)}};
            c_beat[k] = {8{8'(8'hC0 + k)}};
            d_beat[k] = {8{8'(8'hD0 + k)}};
            w_beat[k] = {4{32'(32'h1000_0000 + k)}};
            n_beat[k] = 32'(32'h5000_0000 + k);
        end
        a_line = {a_beat[3], a_beat[2], a_beat[1], a_beat[0]};

        reset = 1'b1; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
        resp_i = 0; burst_i = '0;
        p_read = 0; p_resp = 0; p_addr = '0; w_burst_i = '0; n_burst_i = '0;
        #1;
        chk("rst_line_o", 512'(line_o), 512'd0);
        chk("rst_addr_o", 512'(address_o), 512'd0);
        chk("rst_ctrl", 512'({read_o, write_o, resp_o}), 512'd0);
        chk("rst_burst_o", 512'(burst_o), 512'd0);
        tick();
        tick();
        reset = 1'b0;

        // read with 4 back-to-back beats
        read_i = 1; address_i = 32'h0000_1234;
        tick();
        chk("rd_accept_read_o", 512'(read_o), 512'd1);
        chk("rd_addr_o", 512'(address_o), 512'h0000_1220);
        resp_i = 1;
        for (int k = 0; k < 3; k++) begin
            burst_i = a_beat[k];
            tick();
            chk("rd_mid_read_o", 512'(read_o), 512'd1);
            chk("rd_mid_resp_o", 512'(resp_o), 512'd0);
        end
        burst_i = a_beat[3];
        tick();
        chk("rd_done_read_o", 512'(read_o), 512'd0);
        chk("rd_done_resp_o", 512'(resp_o), 512'd1);
        chk("rd_line_o", 512'(line_o), 512'(a_line));
        read_i = 0; resp_i = 0; burst_i = '0;
        tick();
        chk("rd_resp_pulse", 512'(resp_o), 512'd0);

        // write with gaps; line_i/address_i changes mid-transfer are ignored
        write_i = 1; address_i = 32'h0000_ABCD;
        line_i = {d_beat[3], d_beat[2], d_beat[1], d_beat[0]};
        tick();
        chk("wr_write_o", 512'(write_o), 512'd1);
        chk("wr_addr_o", 512'(address_o), 512'h0000_ABC0);
        chk("wr_burst0", 512'(burst_o), 512'(d_beat[0]));
        line_i = '1; address_i = 32'hFFFF_FFFF;
        resp_i = 1; tick(); chk("wr_p1", 512'(burst_o), 512'(d_beat[1]));
        resp_i = 0; tick(); chk("wr_p2", 512'(burst_o), 512'(d_beat[1]));
        resp_i = 1; tick(); chk("wr_p3", 512'(burst_o), 512'(d_beat[2]));
        resp_i = 0; tick(); chk("wr_p4", 512'(burst_o), 512'(d_beat[2]));
        tick();             chk("wr_p5", 512'(burst_o), 512'(d_beat[2]));
        chk("wr_gap_resp_o", 512'(resp_o), 512'd0);
        chk("wr_addr_hold", 512'(address_o), 512'h0000_ABC0);
        resp_i = 1; tick(); chk("wr_p6", 512'(burst_o), 512'(d_beat[3]));
        chk("wr_p6_resp_o", 512'(resp_o), 512'd0);
        tick();
        chk("wr_done_resp_o", 512'(resp_o), 512'd1);
        chk("wr_done_write_o", 512'(write_o), 512'd0);
        chk("wr_done_burst_o", 512'(burst_o), 512'd0);
        chk("wr_line_o_hold", 512'(line_o), 512'(a_line));
        write_i = 0; resp_i = 0;
        tick();
        chk("wr_resp_pulse", 512'(resp_o), 512'd0);

        // simultaneous read+write: write wins, line_o untouched
        read_i = 1; write_i = 1; address_i = 32'h0000_0100; line_i = {4{c_beat[0]}};
        tick();
        chk("both_ctrl", 512'({read_o, write_o}), 512'b01);
        chk("both_line_o", 512'(line_o), 512'(a_line));
        resp_i = 1;
        tick(); tick(); tick(); tick();
        chk("both_resp_o", 512'(resp_o), 512'd1);
        chk("both_line_o_end", 512'(line_o), 512'(a_line));
        read_i = 0; write_i = 0;

        // spurious resp_i while idle
        tick(); tick();
        chk("spur_ctrl", 512'({read_o, write_o, resp_o}), 512'd0);
        chk("spur_burst_o", 512'(burst_o), 512'd0);
        resp_i = 0;

        // reset after two read beats, asserted between edges
        read_i = 1; address_i = 32'h0000_0040;
        tick();
        resp_i = 1;
        burst_i = 64'hB0B0_B0B0_B0B0_B0B0; tick();
        burst_i = 64'hB1B1_B1B1_B1B1_B1B1; tick();
        #3 reset = 1'b1;
        #1;
        chk("arst_read_o", 512'(read_o), 512'd0);
        chk("arst_addr_o", 512'(address_o), 512'd0);
        chk("arst_line_o", 512'(line_o), 512'd0);
        chk("arst_resp_o", 512'(resp_o), 512'd0);
        tick();
        chk("arst_hold_resp_o", 512'(resp_o), 512'd0);
        reset = 1'b0; resp_i = 0;
        tick();
        chk("post_rst_read_o", 512'(read_o), 512'd1);
        chk("post_rst_addr_o", 512'(address_o), 512'h0000_0040);
        resp_i = 1;
        for (int k = 0; k < 4; k++) begin
            burst_i = c_beat[k];
            tick();
        end
        chk("post_rst_resp_o", 512'(resp_o), 512'd1);
        chk("post_rst_line_o", 512'(line_o), 512'({c_beat[3], c_beat[2], c_beat[1], c_beat[0]}));
        read_i = 0; resp_i = 0;
        tick();

        // alternate parameter builds
        p_read = 1; p_addr = 32'h1234_5678;
        tick();
        chk("wide_addr_o", 512'(w_addr_o), 512'h1234_5640);
        chk("narrow_addr_o", 512'(n_addr_o), 512'h1234_5670);
        p_resp = 1;
        for (int k = 0; k < 3; k++) begin
            w_burst_i = w_beat[k]; n_burst_i = n_beat[k];
            tick();
        end
        chk("wide_mid_resp", 512'({w_resp_o, n_resp_o}), 512'd0);
        w_burst_i = w_beat[3]; n_burst_i = n_beat[3];
        tick();
        chk("wide_resp_o", 512'({w_resp_o, n_resp_o}), 512'b11);
        chk("wide_line_o", w_line_o, {w_beat[3], w_beat[2], w_beat[1], w_beat[0]});
        chk("narrow_line_o", 512'(n_line_o), 512'({n_beat[3], n_beat[2], n_beat[1], n_beat[0]}));
        p_read = 0; p_resp = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
